// File: rtl/conv_layer_engine.sv
// Single-layer KxK convolution over an IMGxIMG map, CH filters in parallel; one output per K*K+1 cycles.
// Results held on out_data while out_ready is low; MAC stalls until the handshake.
module conv_layer_engine #(
    parameter int DW  = 8,
    parameter int AW  = 32,
    parameter int IMG = 16,
    parameter int K   = 4,
    parameter int CH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         img_we,
    input  logic [$clog2(IMG*IMG)-1:0]   img_addr,
    input  logic [DW-1:0]                img_wdata,
    input  logic                         flt_we,
    input  logic [$clog2(CH)-1:0]        flt_ch,
    input  logic [$clog2(K*K)-1:0]       flt_addr,
    input  logic [DW-1:0]                flt_wdata,
    input  logic                         start,
    input  logic                         stride2,
    input  logic                         relu_en,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH*AW-1:0]             out_data,
    output logic [$clog2(IMG)-1:0]       out_row,
    output logic [$clog2(IMG)-1:0]       out_col
);
    localparam int IAW   = $clog2(IMG*IMG);
    localparam int TAW   = $clog2(K*K);
    localparam int RW    = $clog2(IMG);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int LAST1 = IMG - K;
    localparam int LAST2 = (IMG - K) / 2;

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

    state_t state;
    logic signed [DW-1:0]   img_mem [IMG*IMG];
    logic signed [DW-1:0]   flt_mem [CH][K*K];
    logic signed [AW-1:0]   acc      [CH];
    logic signed [AW-1:0]   acc_next [CH];
    logic signed [2*DW-1:0] prod     [CH];
    logic signed [DW-1:0]   pix;
    logic [IAW-1:0]         pix_idx;
    logic [TAW-1:0]         tap_idx;
    logic [RW-1:0]          row, col, last_idx;
    logic [KW-1:0]          kr, kc;
    logic                   stride_q, relu_q;

    // Memories are never reset so contents survive both reset and passes.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (img_we && (32'(img_addr) < 32'(IMG*IMG)))
                img_mem[img_addr] <= img_wdata;
            if (flt_we && (32'(flt_ch) < 32'(CH)) && (32'(flt_addr) < 32'(K*K)))
                flt_mem[flt_ch][flt_addr] <= flt_wdata;
        end
    end

    always_comb begin
        pix_idx  = IAW'(((32'(row) << stride_q) + 32'(kr)) * 32'(IMG)
                        + (32'(col) << stride_q) + 32'(kc));
        tap_idx  = TAW'(32'(kr) * 32'(K) + 32'(kc));
        pix      = img_mem[pix_idx];
        last_idx = stride_q ? RW'(LAST2) : RW'(LAST1);
        for (int c = 0; c < CH; c++) begin
            prod[c]     = (2*DW)'(pix) * (2*DW)'(flt_mem[c][tap_idx]);
            acc_next[c] = acc[c] + AW'(prod[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            row       <= '0;
            col       <= '0;
            kr        <= '0;
            kc        <= '0;
            stride_q  <= 1'b0;
            relu_q    <= 1'b0;
            for (int c = 0; c < CH; c++) acc[c] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        stride_q <= stride2;
                        relu_q   <= relu_en;
                        row      <= '0;
                        col      <= '0;
                        kr       <= '0;
                        kc       <= '0;
                        for (int c = 0; c < CH; c++) acc[c] <= '0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    for (int c = 0; c < CH; c++) acc[c] <= acc_next[c];
                    if (kc == KW'(K-1)) begin
                        kc <= '0;
                        if (kr == KW'(K-1)) begin
                            // Final tap: publish the completed sums directly from acc_next.
                            kr        <= '0;
                            out_valid <= 1'b1;
                            out_row   <= row;
                            out_col   <= col;
                            for (int c = 0; c < CH; c++)
                                out_data[c*AW +: AW] <= (relu_q && acc_next[c][AW-1]) ? '0 : acc_next[c];
                            state     <= EMIT;
                        end else begin
                            kr <= kr + 1'b1;
                        end
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (row == last_idx && col == last_idx) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            if (col == last_idx) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            for (int c = 0; c < CH; c++) acc[c] <= '0;
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine with an arithmetic reference model of the convolution.
module tb_conv_layer_engine;
    localparam int DW = 8, AW = 32, IMG = 16, K = 4, CH = 4;

    logic clk = 1'b0;
    logic rst_n, img_we, flt_we, start, stride2, relu_en, out_ready;
    logic [7:0] img_addr;
    logic [DW-1:0] img_wdata, flt_wdata;
    logic [1:0] flt_ch;
    logic [3:0] flt_addr;
    logic busy, done, out_valid;
    logic [CH*AW-1:0] out_data;
    logic [3:0] out_row, out_col;

    int checks = 0;
    int errs   = 0;

    logic signed [7:0] m_img [IMG*IMG];
    logic signed [7:0] m_flt [CH][K*K];

    logic [127:0] fd, ld;

    conv_layer_engine #(.DW(DW), .AW(AW), .IMG(IMG), .K(K), .CH(CH)) dut (
        .clk(clk), .rst_n(rst_n),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .flt_we(flt_we), .flt_ch(flt_ch), .flt_addr(flt_addr), .flt_wdata(flt_wdata),
        .start(start), .stride2(stride2), .relu_en(relu_en),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_img(input int a, input logic [7:0] d);
        img_we = 1'b1; img_addr = 8'(a); img_wdata = d;
        @(posedge clk); #1;
        img_we = 1'b0;
        m_img[a] = d;
    endtask

    task automatic wr_flt(input int ch, input int a, input logic [7:0] d);
        flt_we = 1'b1; flt_ch = 2'(ch); flt_addr = 4'(a); flt_wdata = d;
        @(posedge clk); #1;
        flt_we = 1'b0;
        m_flt[ch][a] = d;
    endtask

    // Direct sum over the window, wrapped to AW bits, optional clamp.
    function automatic logic [127:0] model_vec(int r, int c, bit s2, bit relu);
        logic [127:0] v;
        longint acc;
        logic [31:0] a32;
        int s;
        s = s2 ? 2 : 1;
        v = '0;
        for (int ch = 0; ch < CH; ch++) begin
            acc = 0;
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    acc += longint'(m_img[(r*s+kr)*IMG + c*s+kc]) * longint'(m_flt[ch][kr*K+kc]);
            a32 = acc[31:0];
            if (relu && a32[31]) a32 = '0;
            v[ch*32 +: 32] = a32;
        end
        return v;
    endfunction

    task automatic run_pass(input bit s2, input bit relu, input int stall_idx, input int poke_idx,
                            input int abort_idx, output logic [127:0] first_d, output logic [127:0] last_d);
        int n, out_idx, phase, stalls, first_valid, done_cyc, nout, exp_r, exp_c;
        bit prev_valid, prev_hs, hs, finished, done_seen;
        nout = s2 ? 7 : 13;
        exp_r = 0; exp_c = 0; out_idx = 0; phase = 0; stalls = 0;
        first_valid = -1; done_cyc = -1; prev_valid = 0; prev_hs = 0; finished = 0;
        first_d = '0; last_d = '0;
        @(negedge clk);
        start = 1'b1; stride2 = s2; relu_en = relu; out_ready = 1'b1;
        @(posedge clk);
        n = 1;
        while (!finished) begin
            @(negedge clk);
            start = 1'b0; img_we = 1'b0;
            if (abort_idx >= 0 && out_idx == abort_idx && phase == 5) begin
                rst_n = 1'b0;
                @(posedge clk); @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_valid", out_valid, 0);
                chk("abort_done", done, 0);
                rst_n = 1'b1;
                done_seen = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (done) done_seen = 1;
                end
                chk("abort_no_done", done_seen, 0);
                return;
            end
            if (out_valid && out_idx == stall_idx && stalls < 10) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            hs = out_valid && out_ready;
            if (prev_valid && !prev_hs) chk("valid_held", out_valid, 1);
            if (out_valid) begin
                if (first_valid < 0) begin
                    first_valid = n;
                    chk("first_valid_cycle", n, K*K+1);
                end
                chk("out_data", out_data, model_vec(exp_r, exp_c, s2, relu));
                chk("out_row", out_row, exp_r);
                chk("out_col", out_col, exp_c);
                if (!out_ready) chk("stall_ch0", out_data[31:0], 5);
                if (out_idx == 0) first_d = out_data;
                if (hs) begin
                    last_d = out_data;
                    out_idx++;
                    phase = 0;
                    if (exp_c == nout-1) begin exp_c = 0; exp_r++; end
                    else exp_c++;
                end
            end else begin
                phase++;
            end
            if (done && done_cyc < 0) done_cyc = n;
            if (done_cyc >= 0 && n == done_cyc + 1) begin
                chk("busy_drop", busy, 0);
                chk("done_cycle", done_cyc, nout*nout*(K*K+1) + 1 + stalls);
                chk("out_count", out_idx, nout*nout);
                finished = 1;
            end
            if (poke_idx >= 0 && out_idx == poke_idx && phase == 3 && !out_valid) begin
                start = 1'b1; img_we = 1'b1; img_addr = 8'd0; img_wdata = 8'd99;
            end
            prev_valid = out_valid;
            prev_hs = hs;
            if (n > 4000) begin
                errs++;
                checks++;
                $display("FAIL pass_timeout: got no done after %0d cycles, required done", n);
                finished = 1;
            end
            @(posedge clk);
            n++;
        end
        start = 1'b0; img_we = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; img_we = 1'b0; flt_we = 1'b0; start = 1'b0; stride2 = 1'b0;
        relu_en = 1'b0; out_ready = 1'b1; img_addr = '0; img_wdata = '0;
        flt_ch = '0; flt_addr = '0; flt_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        rst_n = 1'b1;

        for (int a = 0; a < IMG*IMG; a++) wr_img(a, 8'd1);
        for (int c = 0; c < CH; c++)
            for (int t = 0; t < K*K; t++) wr_flt(c, t, 8'(c+1));

        run_pass(0, 0, -1, -1, -1, fd, ld);
        chk("s1_first_lit", fd, 128'h00000040_00000030_00000020_00000010);
        chk("s1_last_lit", ld, 128'h00000040_00000030_00000020_00000010);

        run_pass(1, 0, -1, -1, -1, fd, ld);
        chk("s2_last_lit", ld, 128'h00000040_00000030_00000020_00000010);

        for (int t = 0; t < K*K; t++) wr_flt(0, t, 8'hFF);
        run_pass(1, 0, -1, -1, -1, fd, ld);
        chk("neg_ch0_lit", fd[31:0], 32'hFFFFFFF0);
        run_pass(1, 1, -1, -1, -1, fd, ld);
        chk("relu_lit", fd, 128'h00000040_00000030_00000020_00000000);

        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++) wr_img(r*IMG + c, 8'(c));
        for (int t = 0; t < K*K; t++) wr_flt(0, t, (t == 0) ? 8'd1 : 8'd0);
        run_pass(0, 0, 5, -1, -1, fd, ld);
        chk("ramp_first_ch0", fd[31:0], 32'd0);
        chk("ramp_last_ch0", ld[31:0], 32'd12);

        run_pass(1, 0, -1, 1, -1, fd, ld);
        run_pass(0, 0, -1, -1, 3, fd, ld);
        run_pass(1, 0, -1, -1, -1, fd, ld);
        chk("mem_kept_ch0", fd[31:0], 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
